io_peripheral: RTL and testbench
================================

IO_PERIPHERAL -- requirements
Module: io_peripheral

Interface
REQ-001 Clock and reset: clk is the single clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces every register to its reset value.
REQ-004 MemRead  input  1  CPU load strobe, qualifies Address for reads.
REQ-005 MemWrite  input  1  CPU store strobe; write commits on the rising edge of clk.
REQ-006 Address  input  32  CPU byte address; decoded per REQ-010.
REQ-007 Write_data  input  32  CPU store data.
REQ-008 Read_data  output  32  combinational load data, valid in the same cycle as MemRead.
REQ-009 digi_an  output  4  digit-enable bits, equal to DIGI[11:8]; digi_seg  output  8  segment bits, equal to DIGI[7:0]; irq  output  1  timer interrupt, equal to TCON[2].

Function
REQ-010 Register map (word-aligned; Address[1:0] ignored): 0x00004000 DIGI (12 bits, RW); 0x00004004 SYSTICK (32 bits, RO); 0x00004008 TH (32 bits, RW); 0x0000400C TL (32 bits, RW); 0x00004010 TCON (3 bits, RW).
REQ-011 Any other address: writes are ignored and Read_data is 0.
REQ-012 Read_data is 0 whenever MemRead=0.
REQ-013 Reads are combinational: Read_data reflects the register value before the edge; narrower registers are zero-extended.
REQ-014 DIGI write: DIGI <= Write_data[11:0]; digi_an and digi_seg change on the same edge, with no extra latency.
REQ-015 SYSTICK: increments by 1 every cycle, wrapping from 0xFFFFFFFF to 0; writes to it are ignored.
REQ-016 TCON bit0 = timer enable, bit1 = irq enable, bit2 = irq status.
REQ-017 When TCON[0]=1, TL increments by 1 per cycle; when TCON[0]=0, TL holds.
REQ-018 Overflow: when TCON[0]=1 and TL==0xFFFFFFFF, TL <= TH on the next edge (no pass through 0).
REQ-019 On overflow, TCON[2] <= 1 if TCON[1]=1; otherwise TCON[2] is unchanged.
REQ-020 TCON[2] is sticky: it clears only by a CPU write of 0 to bit2 or by reset.
REQ-021 A CPU write to TCON with bit2=1 sets TCON[2] directly.
REQ-022 Simultaneous events: a CPU write to TL, TCON or TH in the overflow cycle wins over the timer update for that register.
REQ-023 When a TH write coincides with overflow, TL reloads from the old TH value.
REQ-024 MemRead and MemWrite asserted together: the read returns the pre-write value and the write commits.

Reset
REQ-025 During reset: DIGI=0, SYSTICK=0, TH=0, TL=0, TCON=0.
REQ-026 During reset: digi_an=0, digi_seg=0, irq=0; Read_data follows REQ-012/013 from these values.
REQ-027 Reset asserted mid-count clears state immediately, without waiting for a clk edge.
REQ-028 After reset deasserts, SYSTICK counts from 0 beginning on the first rising edge.

Verification
REQ-029 DIGI write then read: write 0x0000013F to 0x4000 -> digi_an=4'b0001, digi_seg=0x3F next cycle; read 0x4000 returns 0x0000013F; a write of 0xFFFFF871 reads back 0x00000871.
REQ-030 Timer overflow: TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3 -> TL reads 0xFFFFFFFF, then 0xFFFFFFFC; irq rises on the reload edge; write TCON=3 -> irq=0 while counting continues.
REQ-031 Interrupt masked: same setup with TCON=1 -> TL reloads, irq stays 0.
REQ-032 Collision: write TL=0x00000010 in the overflow cycle -> TL=0x00000010 next cycle; irq set per TCON[1].
REQ-033 Decode and SYSTICK: write 0x1234 to 0x4020 -> no register changes and read returns 0; SYSTICK read at cycle N and N+5 differs by 5; a write to 0x4004 has no effect.
REQ-034 Async reset: assert reset between edges while TL is counting -> all outputs 0 immediately; release -> SYSTICK=1 after the first edge.

Source files
------------

// File: rtl/io_peripheral.sv
// Memory-mapped I/O block: seven-segment digit register, free-running
// SYSTICK counter and a reloadable 32-bit timer with a sticky interrupt.
// Loads are combinational; stores commit on the rising clock edge.
module io_peripheral (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [3:0]  digi_an,
    output logic [7:0]  digi_seg,
    output logic        irq
);

    // Word addresses (byte address >> 2)
    localparam logic [29:0] WordDigi    = 30'h0000_1000;
    localparam logic [29:0] WordSystick = 30'h0000_1001;
    localparam logic [29:0] WordTh      = 30'h0000_1002;
    localparam logic [29:0] WordTl      = 30'h0000_1003;
    localparam logic [29:0] WordTcon    = 30'h0000_1004;

    // TCON bit positions
    localparam int unsigned TconEn    = 0;
    localparam int unsigned TconIrqEn = 1;
    localparam int unsigned TconIrq   = 2;

    logic [11:0] r_digi;
    logic [31:0] r_systick;
    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;

    logic [11:0] w_digi_d;
    logic [31:0] w_th_d;
    logic [31:0] w_tl_d;
    logic [2:0]  w_tcon_d;

    logic [29:0] w_word;
    logic        w_wr_digi;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_overflow;

    // Byte offset within a word is not decoded.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^Address[1:0];

    assign w_word    = Address[31:2];
    assign w_wr_digi = MemWrite && (w_word == WordDigi);
    assign w_wr_th   = MemWrite && (w_word == WordTh);
    assign w_wr_tl   = MemWrite && (w_word == WordTl);
    assign w_wr_tcon = MemWrite && (w_word == WordTcon);

    // Running timer at all-ones reloads from TH instead of wrapping to zero.
    assign w_overflow = r_tcon[TconEn] && (r_tl == 32'hFFFF_FFFF);

    // Next-state for DIGI: plain CPU-written register.
    always_comb begin
        w_digi_d = r_digi;
        if (w_wr_digi) begin
            w_digi_d = Write_data[11:0];
        end
    end

    // Next-state for TH: plain CPU-written register.
    always_comb begin
        w_th_d = r_th;
        if (w_wr_th) begin
            w_th_d = Write_data;
        end
    end

    // Next-state for TL: CPU write wins, else reload on overflow, else count.
    // Reload uses r_th, so a coincident TH write does not affect this reload.
    always_comb begin
        w_tl_d = r_tl;
        if (w_wr_tl) begin
            w_tl_d = Write_data;
        end else if (w_overflow) begin
            w_tl_d = r_th;
        end else if (r_tcon[TconEn]) begin
            w_tl_d = r_tl + 32'd1;
        end
    end

    // Next-state for TCON: CPU write wins, else overflow sets the sticky
    // status bit when the interrupt is enabled.
    always_comb begin
        w_tcon_d = r_tcon;
        if (w_wr_tcon) begin
            w_tcon_d = Write_data[2:0];
        end else if (w_overflow && r_tcon[TconIrqEn]) begin
            w_tcon_d[TconIrq] = 1'b1;
        end
    end

    // DIGI register; drives the display pins directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digi <= 12'd0;
        end else begin
            r_digi <= w_digi_d;
        end
    end

    // Free-running SYSTICK; not writable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_systick <= 32'd0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    // Timer reload value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th <= 32'd0;
        end else begin
            r_th <= w_th_d;
        end
    end

    // Timer count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tl <= 32'd0;
        end else begin
            r_tl <= w_tl_d;
        end
    end

    // Timer control and sticky interrupt status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcon <= 3'd0;
        end else begin
            r_tcon <= w_tcon_d;
        end
    end

    // Combinational load mux; zero when not reading or unmapped.
    always_comb begin
        Read_data = 32'd0;
        if (MemRead) begin
            case (w_word)
                WordDigi:    Read_data = {20'd0, r_digi};
                WordSystick: Read_data = r_systick;
                WordTh:      Read_data = r_th;
                WordTl:      Read_data = r_tl;
                WordTcon:    Read_data = {29'd0, r_tcon};
                default:     Read_data = 32'd0;
            endcase
        end
    end

    assign digi_an  = r_digi[11:8];
    assign digi_seg = r_digi[7:0];
    assign irq      = r_tcon[TconIrq];

endmodule

// File: tb/tb_io_peripheral.sv
// Directed bench for io_peripheral: display register, decode, SYSTICK,
// timer reload/interrupt, write collisions and asynchronous reset.
module tb_io_peripheral;

    localparam logic [31:0] ADigi    = 32'h0000_4000;
    localparam logic [31:0] ASystick = 32'h0000_4004;
    localparam logic [31:0] ATh      = 32'h0000_4008;
    localparam logic [31:0] ATl      = 32'h0000_400C;
    localparam logic [31:0] ATcon    = 32'h0000_4010;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic [3:0]  digi_an;
    logic [7:0]  digi_seg;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference cycle counter for SYSTICK.
    logic [31:0] tb_tick;

    io_peripheral dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .digi_an    (digi_an),
        .digi_seg   (digi_seg),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) tb_tick <= 32'd0;
        else       tb_tick <= tb_tick + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address    = addr;
        Write_data = data;
        MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Address = addr;
        MemRead = 1'b1;
        #1;
        check(tag, Read_data, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = 32'd0;
        Write_data = 32'd0;

        // Reset state
        #3;
        check("rst_an", 32'(digi_an), 32'd0);
        check("rst_seg", 32'(digi_seg), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rd("rst_systick", ASystick, 32'd0);
        #5;
        reset = 1'b0;
        step(1);
        rd("systick_first", ASystick, 32'd1);

        // DIGI write/read
        wr(ADigi, 32'h0000_013F);
        check("digi_an_1", 32'(digi_an), 32'h1);
        check("digi_seg_1", 32'(digi_seg), 32'h3F);
        rd("digi_rd_1", ADigi, 32'h0000_013F);
        wr(ADigi, 32'hFFFF_F871);
        rd("digi_rd_2", ADigi, 32'h0000_0871);
        check("digi_an_2", 32'(digi_an), 32'h8);

        // Timer overflow with interrupt enabled
        wr(ATh, 32'hFFFF_FFFC);
        wr(ATl, 32'hFFFF_FFFE);
        wr(ATcon, 32'd3);
        rd("ovf_tl0", ATl, 32'hFFFF_FFFE);
        step(1);
        rd("ovf_tl1", ATl, 32'hFFFF_FFFF);
        check("ovf_irq_pre", 32'(irq), 32'd0);
        step(1);
        rd("ovf_reload", ATl, 32'hFFFF_FFFC);
        check("ovf_irq_set", 32'(irq), 32'd1);
        rd("ovf_tcon", ATcon, 32'd7);
        wr(ATcon, 32'd3);
        check("irq_clear", 32'(irq), 32'd0);
        rd("cnt_after_clr", ATl, 32'hFFFF_FFFD);
        step(1);
        rd("cnt_cont", ATl, 32'hFFFF_FFFE);

        // Masked interrupt
        wr(ATcon, 32'd0);
        wr(ATl, 32'hFFFF_FFFE);
        wr(ATcon, 32'd1);
        step(1);
        rd("msk_tl1", ATl, 32'hFFFF_FFFF);
        step(1);
        rd("msk_reload", ATl, 32'hFFFF_FFFC);
        check("msk_irq", 32'(irq), 32'd0);
        rd("msk_tcon", ATcon, 32'd1);

        // TL write in overflow cycle
        wr(ATcon, 32'd0);
        wr(ATl, 32'hFFFF_FFFE);
        wr(ATcon, 32'd3);
        step(1);
        rd("col_tl_ff", ATl, 32'hFFFF_FFFF);
        wr(ATl, 32'h0000_0010);
        rd("col_tl_wins", ATl, 32'h0000_0010);
        check("col_irq", 32'(irq), 32'd1);
        step(1);
        rd("col_tl_next", ATl, 32'h0000_0011);

        // TCON write in overflow cycle
        wr(ATcon, 32'd3);
        wr(ATl, 32'hFFFF_FFFF);
        wr(ATcon, 32'd1);
        rd("tcon_col_val", ATcon, 32'd1);
        check("tcon_col_irq", 32'(irq), 32'd0);
        rd("tcon_col_tl", ATl, 32'hFFFF_FFFC);

        // TH write in overflow cycle: reload uses old TH
        wr(ATl, 32'hFFFF_FFFF);
        wr(ATh, 32'h0000_0100);
        rd("th_col_tl", ATl, 32'hFFFF_FFFC);
        rd("th_col_th", ATh, 32'h0000_0100);

        // Direct set of status bit
        wr(ATcon, 32'd4);
        check("tcon_set_irq", 32'(irq), 32'd1);
        rd("tcon_set_rd", ATcon, 32'd4);
        wr(ATcon, 32'd0);
        check("tcon_clr_irq", 32'(irq), 32'd0);

        // Unmapped address
        wr(32'h0000_4020, 32'h0000_1234);
        rd("unmapped_rd", 32'h0000_4020, 32'd0);
        rd("unmapped_digi", ADigi, 32'h0000_0871);
        rd("unmapped_th", ATh, 32'h0000_0100);
        rd("tl_held", ATl, 32'hFFFF_FFFD);

        // SYSTICK counting and write-protect
        rd("systick_n", ASystick, tb_tick);
        step(5);
        rd("systick_n5", ASystick, tb_tick);
        wr(ASystick, 32'd0);
        rd("systick_ro", ASystick, tb_tick);

        // Read strobe low and ignored byte offset
        Address = ADigi;
        MemRead = 1'b0;
        #1;
        check("rd_gate", Read_data, 32'd0);
        rd("addr_lsb", 32'h0000_4003, 32'h0000_0871);

        // Simultaneous read and write
        step(1);
        Address    = ADigi;
        Write_data = 32'h0000_00AA;
        MemRead    = 1'b1;
        MemWrite   = 1'b1;
        #1;
        check("rw_pre", Read_data, 32'h0000_0871);
        @(posedge clk);
        #1;
        check("rw_post", Read_data, 32'h0000_00AA);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        check("rw_seg", 32'(digi_seg), 32'hAA);

        // Async reset mid-count
        wr(ATcon, 32'd5);
        check("pre_rst_irq", 32'(irq), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_seg", 32'(digi_seg), 32'd0);
        check("arst_an", 32'(digi_an), 32'd0);
        rd("arst_tl", ATl, 32'd0);
        rd("arst_tcon", ATcon, 32'd0);
        reset = 1'b0;
        step(1);
        rd("arst_systick", ASystick, 32'd1);
        step(1);
        rd("arst_tl_hold", ATl, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
